// File: rtl/act_pkg.sv
// Shared types and constants for the piecewise-linear activation evaluator.
//   ACT_W          sample / result / coefficient width
//   FRAC_W         width of the segment fraction taken from the sample LSBs
//   DEF_FRAC_SHIFT default right shift applied to slope * frac
package act_pkg;

  localparam int unsigned ACT_W          = 8;
  localparam int unsigned FRAC_W         = 4;
  localparam int unsigned DEF_FRAC_SHIFT = 5;
  localparam int unsigned PROD_W         = ACT_W + FRAC_W;

  typedef logic [ACT_W-1:0]  act_t;
  typedef logic [FRAC_W-1:0] frac_t;

  typedef struct packed {
    act_t slope;
    act_t offset;
  } coef_t;

endpackage

// File: rtl/act_pwl_eval_if.sv
// Sample/result stream bundle for act_pwl_eval.
//   in_valid/in_ready/in_data/in_type   : sample stream into the evaluator
//   out_valid/out_ready/out_data        : activation result stream
//   out_count                           : transferred-result counter (wraps)
// slave  = evaluator side, master = producer/consumer side.
interface act_pwl_eval_if #(
  parameter int unsigned CNT_W = 16
) ();
  import act_pkg::*;

  logic             in_valid;
  logic             in_ready;
  act_t             in_data;
  logic             in_type;
  logic             out_valid;
  logic             out_ready;
  act_t             out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_type, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_type, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/act_pwl_mac.sv
// Combinational multiply-add-saturate for one PWL segment:
//   y = sat8(offset + ((slope * frac) >> FRAC_SHIFT))
// Ports: slope, offset (unsigned 8-bit), frac (4-bit), y (unsigned Q0.8).
module act_pwl_mac
  import act_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT
) (
  input  act_t  slope,
  input  act_t  offset,
  input  frac_t frac,
  output act_t  y
);

  logic [PROD_W-1:0] prod;
  logic [ACT_W:0]    sum;

  always_comb begin
    prod = PROD_W'(slope) * PROD_W'(frac);
    sum  = {1'b0, offset} + (ACT_W+1)'(prod >> FRAC_SHIFT);
    // carry out of the 8-bit add means the result exceeds full scale
    y    = sum[ACT_W] ? '1 : sum[ACT_W-1:0];
  end

endmodule

// File: rtl/act_pwl_eval.sv
// Pipelined piecewise-linear activation evaluator.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          sample in / result out streams plus result counter
//   coef_x       registered sample presented to the external coefficient unit
//   coef_type    segment-format select presented with coef_x
//   coef_slope   slope returned combinationally for coef_x
//   coef_offset  offset returned combinationally for coef_x
// Pipeline: S1 (sample) -> S2 (coefficients) -> S3 (mac result) -> output
// register. A single global advance moves every stage together, so a stall
// at the output freezes the whole pipe and in_ready drops in the same cycle.
module act_pwl_eval
  import act_pkg::*;
#(
  parameter int unsigned FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int unsigned CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst,
  act_pwl_eval_if.slave bus,
  output act_t          coef_x,
  output logic          coef_type,
  input  act_t          coef_slope,
  input  act_t          coef_offset
);

  logic             adv;
  logic             s1_valid;
  act_t             s1_x;
  logic             s1_type;
  logic             s2_valid;
  coef_t            s2_coef;
  frac_t            s2_frac;
  logic             s3_valid;
  act_t             s3_y;
  act_t             mac_y;
  logic             out_valid_q;
  act_t             out_data_q;
  logic [CNT_W-1:0] count_q;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = count_q;
  assign coef_x        = s1_x;
  assign coef_type     = s1_type;

  // Stage valids: bubbles travel with the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s3_valid    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid    <= bus.in_valid;
      s2_valid    <= s1_valid;
      s3_valid    <= s2_valid;
      out_valid_q <= s3_valid;
    end
  end

  // Datapath: later stages only load behind a valid stage so out_data keeps
  // its last real value across bubbles and never picks up undriven data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_x       <= '0;
      s1_type    <= 1'b0;
      s2_coef    <= '0;
      s2_frac    <= '0;
      s3_y       <= '0;
      out_data_q <= '0;
    end else if (adv) begin
      s1_x    <= bus.in_data;
      s1_type <= bus.in_type;
      if (s1_valid) begin
        s2_coef <= '{slope: coef_slope, offset: coef_offset};
        s2_frac <= s1_x[FRAC_W-1:0];
      end
      if (s2_valid) s3_y <= mac_y;
      if (s3_valid) out_data_q <= s3_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             count_q <= '0;
    else if (out_valid_q && bus.out_ready) count_q <= count_q + 1'b1;
  end

  act_pwl_mac #(
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_mac (
    .slope (s2_coef.slope),
    .offset(s2_coef.offset),
    .frac  (s2_frac),
    .y     (mac_y)
  );

endmodule
